// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
//   Receive end of the gate servo PWM link. Synchronises the incoming servo
//   PWM line, measures each high pulse in clk cycles and checks it against the
//   legal servo pulse window. Reports the last legal width, the decoded gate
//   position and loss of signal.
//
// Ports
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-low reset
//   pwm_in       in   1      servo PWM line, asynchronous to clk
//   pulse_width  out  CNT_W  width of last legal pulse, cycles
//   pulse_valid  out  1      1-cycle strobe: new legal pulse_width available
//   pulse_error  out  1      1-cycle strobe: pulse too short or too long
//   gate_open    out  1      1 = last legal pulse >= OPEN_THRESH
//   signal_lost  out  1      1 = no rising edge / legal pulse within timeout
//
// State     | meaning
// ----------+---------------------------------------------------------------
// WAIT_LOW  | line not trusted yet; wait for a settled low before measuring
// IDLE      | line low, waiting for a rising edge
// HIGH      | measuring a high pulse in hi_cnt
module servo_pwm_decoder #(
  parameter int CNT_W          = 21,
  parameter int MIN_PULSE      = 50_000,
  parameter int MAX_PULSE      = 100_000,
  parameter int OPEN_THRESH    = 75_000,
  parameter int PERIOD_TIMEOUT = 1_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] pulse_width,
  output logic             pulse_valid,
  output logic             pulse_error,
  output logic             gate_open,
  output logic             signal_lost
);

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] OVER_C    = CNT_W'(MAX_PULSE + 1);
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(OPEN_THRESH);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(PERIOD_TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             pwm_prev_q, pwm_prev_d;
  logic [1:0]       sync_vld_q, sync_vld_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] pulse_width_q, pulse_width_d;
  logic             pulse_valid_q, pulse_valid_d;
  logic             pulse_error_q, pulse_error_d;
  logic             gate_open_q, gate_open_d;
  logic             signal_lost_q, signal_lost_d;

  logic pwm_s;
  logic rise;
  logic fall;

  assign pwm_s = sync2_q;
  assign rise  = pwm_s & ~pwm_prev_q;
  assign fall  = ~pwm_s & pwm_prev_q;

  always_comb begin
    state_d       = state_q;
    sync1_d       = pwm_in;
    sync2_d       = sync1_q;
    pwm_prev_d    = pwm_s;
    // The synchronizer resets to 0, so its output means nothing until two
    // samples of the real line have passed through it. Without this a line
    // held high across reset release would look like a fresh rising edge.
    sync_vld_d    = {sync_vld_q[0], 1'b1};
    hi_cnt_d      = hi_cnt_q;
    per_cnt_d     = per_cnt_q;
    pulse_width_d = pulse_width_q;
    pulse_valid_d = 1'b0;
    pulse_error_d = 1'b0;
    gate_open_d   = gate_open_q;
    signal_lost_d = signal_lost_q;

    if (rise) begin
      per_cnt_d = '0;
    end else if (per_cnt_q != TIMEOUT_C) begin
      per_cnt_d = per_cnt_q + ONE_C;
    end

    // Fail-safe closed on timeout; a legal pulse below overrides this.
    if (per_cnt_q == TIMEOUT_C) begin
      signal_lost_d = 1'b1;
      gate_open_d   = 1'b0;
    end

    case (state_q)
      WAIT_LOW: begin
        if (sync_vld_q[1] && !pwm_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (rise) begin
          hi_cnt_d = ONE_C;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (hi_cnt_q >= OVER_C) begin
          pulse_error_d = 1'b1;
          state_d       = WAIT_LOW;
        end else if (fall) begin
          if (hi_cnt_q < MIN_C) begin
            pulse_error_d = 1'b1;
          end else begin
            pulse_valid_d = 1'b1;
            pulse_width_d = hi_cnt_q;
            gate_open_d   = (hi_cnt_q >= THRESH_C);
            signal_lost_d = 1'b0;
          end
          state_d = IDLE;
        end else if (pwm_s) begin
          hi_cnt_d = hi_cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= WAIT_LOW;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      pwm_prev_q    <= 1'b0;
      sync_vld_q    <= 2'b00;
      hi_cnt_q      <= '0;
      per_cnt_q     <= '0;
      pulse_width_q <= '0;
      pulse_valid_q <= 1'b0;
      pulse_error_q <= 1'b0;
      gate_open_q   <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      pwm_prev_q    <= pwm_prev_d;
      sync_vld_q    <= sync_vld_d;
      hi_cnt_q      <= hi_cnt_d;
      per_cnt_q     <= per_cnt_d;
      pulse_width_q <= pulse_width_d;
      pulse_valid_q <= pulse_valid_d;
      pulse_error_q <= pulse_error_d;
      gate_open_q   <= gate_open_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign pulse_width = pulse_width_q;
  assign pulse_valid = pulse_valid_q;
  assign pulse_error = pulse_error_q;
  assign gate_open   = gate_open_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with a small pulse window. A driver issues
// pulses of known length and queues the expected decoder response; a monitor
// pops and compares on every pulse_valid / pulse_error strobe.
module tb_servo_pwm_decoder;

  localparam int CNT_W   = 8;
  localparam int MIN_P   = 10;
  localparam int MAX_P   = 20;
  localparam int THRESH  = 15;
  localparam int TIMEOUT = 100;

  logic             clk;
  logic             reset;
  logic             pwm_in;
  logic [CNT_W-1:0] pulse_width;
  logic             pulse_valid;
  logic             pulse_error;
  logic             gate_open;
  logic             signal_lost;

  servo_pwm_decoder #(
    .CNT_W(CNT_W), .MIN_PULSE(MIN_P), .MAX_PULSE(MAX_P),
    .OPEN_THRESH(THRESH), .PERIOD_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .pulse_width(pulse_width), .pulse_valid(pulse_valid),
    .pulse_error(pulse_error), .gate_open(gate_open),
    .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int width;
    bit gate;
    bit lost;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference view of the decoder's held outputs.
  int m_width = 0;
  bit m_gate  = 1'b0;
  bit m_lost  = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    exp_t e;
    if (hi < MIN_P || hi > MAX_P) begin
      e.is_err = 1'b1;
    end else begin
      e.is_err = 1'b0;
      m_width  = hi;
      m_gate   = (hi >= THRESH);
      m_lost   = 1'b0;
    end
    e.width = m_width;
    e.gate  = m_gate;
    e.lost  = m_lost;
    exp_q.push_back(e);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
    // Gaps are chosen well clear of the timeout so the outcome is unambiguous.
    if (hi + lo > TIMEOUT + 5) begin
      m_lost = 1'b1;
      m_gate = 1'b0;
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_lost"},  int'(signal_lost), int'(m_lost));
    chk({tag, "_gate"},  int'(gate_open),   int'(m_gate));
    chk({tag, "_width"}, int'(pulse_width), m_width);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (pulse_valid && pulse_error) begin
        chk("valid_and_error", 1, 0);
      end
      if (pulse_valid || pulse_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", int'(pulse_error), -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_is_error", int'(pulse_error), int'(mon_e.is_err));
          chk("pulse_width",     int'(pulse_width), mon_e.width);
          chk("gate_open",       int'(gate_open),   int'(mon_e.gate));
          chk("signal_lost",     int'(signal_lost), int'(mon_e.lost));
        end
      end
    end
  end

  initial begin
    reset  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_width", int'(pulse_width), 0);
    chk("rst_valid", int'(pulse_valid), 0);
    chk("rst_error", int'(pulse_error), 0);
    chk("rst_gate",  int'(gate_open),   0);
    chk("rst_lost",  int'(signal_lost), 1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    pulse(17, 30);
    pulse(12, 50);
    pulse(10, 30);
    pulse(20, 30);
    pulse(5, 30);
    pulse(21, 30);
    pulse(40, 30);
    pulse(17, 30);

    pulse(17, 75);
    check_held("no_timeout");
    pulse(17, 120);
    check_held("timeout");
    pulse(3, 30);
    check_held("short_after_timeout");
    pulse(16, 30);

    // Reset in the middle of a pulse, released while the line is still high.
    repeat (10) @(negedge clk);
    chk("queue_drained_before_reset", exp_q.size(), 0);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_width", int'(pulse_width), 0);
    chk("midrst_gate",  int'(gate_open),   0);
    chk("midrst_lost",  int'(signal_lost), 1);
    chk("midrst_valid", int'(pulse_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_width = 0;
    m_gate  = 1'b0;
    m_lost  = 1'b1;
    repeat (12) @(negedge clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    check_held("after_midrst");
    pulse(17, 30);

    for (int i = 0; i < 60; i++) begin
      pulse(int'($urandom_range(3, 30)), int'($urandom_range(5, 60)));
    end

    repeat (30) @(negedge clk);
    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
